hazard_unit: RTL

- Central pipeline sequencer for the 5-stage MIPS core.
- Generates per-stage enable and flush strobes for the PC and the IF_ID, ID_EX, EX_MEM and MEM_WB pipe registers.
- Handles instruction-memory wait, data-memory wait, load-use interlock, taken-branch/jump squash, and halt drain.
- Sits beside the datapath; consumes decoded stage fields and cache hit signals.

---
 rtl/hazard_unit_pkg.sv | 13 +
 rtl/hazard_perf_ctr.sv | 33 +++
 rtl/hazard_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/hazard_unit_pkg.sv
// rtl/hazard_unit_pkg.sv - shared sequencer state encoding and default widths for hazard_unit
package hazard_unit_pkg;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'd0,
    HZ_DWAIT = 2'd1,
    HZ_HALT  = 2'd2
  } hzstate_t;

  localparam int unsigned HZ_REGW_DEF  = 5;
  localparam int unsigned HZ_PERFW_DEF = 32;

endpackage

// File: rtl/hazard_perf_ctr.sv
// rtl/hazard_perf_ctr.sv - saturating event counter with synchronous clear
module hazard_perf_ctr #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - 5-stage pipeline enable/flush sequencer; HAZARD_PERF_EN adds stall/flush counters
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned REGW  = HZ_REGW_DEF,
  parameter int unsigned PERFW = HZ_PERFW_DEF
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            ihit,
  input  logic            dhit,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic            ex_dREN,
  input  logic [REGW-1:0] ex_wsel,
  input  logic            ex_redirect,
  input  logic            mem_dREN,
  input  logic            mem_dWEN,
  input  logic            wb_halt,
  output logic            pc_en,
  output logic            if_id_en,
  output logic            id_ex_en,
  output logic            ex_mem_en,
  output logic            mem_wb_en,
  output logic            if_id_flush,
  output logic            id_ex_flush,
  output logic            ex_mem_flush,
  output logic            mem_wb_flush,
  output logic            halted,
`ifdef HAZARD_PERF_EN
  output logic [PERFW-1:0] stall_cycles,
  output logic [PERFW-1:0] flush_events,
`endif
  output logic [1:0]      state_o
);

  hzstate_t state_q, state_d;
  logic     halted_q, halted_d;
  logic     dmem_req, freeze, load_use;
  logic [3:0] en_c, fl_c;
  logic     pc_en_c;

  assign dmem_req = mem_dREN | mem_dWEN;
  // The entry cycle freezes too, so the outstanding access never slips a stage.
  assign freeze   = ((state_q == HZ_DWAIT) || ((state_q == HZ_RUN) && dmem_req)) && !dhit;
  assign load_use = ex_dREN && (ex_wsel != '0) && ((ex_wsel == id_rs) || (ex_wsel == id_rt));

  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    case (state_q)
      HZ_RUN:   if (dmem_req && !dhit) state_d = HZ_DWAIT;
      HZ_DWAIT: if (dhit) state_d = HZ_RUN;
      HZ_HALT:  state_d = HZ_HALT;
      default:  state_d = HZ_RUN;
    endcase
    if (wb_halt) begin
      state_d  = HZ_HALT;
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= HZ_RUN;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  // en_c/fl_c bit order: {if_id, id_ex, ex_mem, mem_wb}
  always_comb begin
    pc_en_c = ihit;
    en_c    = 4'b1111;
    fl_c    = 4'b0000;
    if (RST) begin
      pc_en_c = 1'b0;
      en_c    = 4'b0000;
      fl_c    = 4'b1111;
    end else if (state_q == HZ_HALT) begin
      pc_en_c = 1'b0;
      en_c    = 4'b0000;
    end else if (freeze) begin
      pc_en_c = 1'b0;
      en_c    = 4'b0000;
    end else if (ex_redirect) begin
      pc_en_c = 1'b1;
      fl_c    = 4'b1100;
    end else if (load_use) begin
      pc_en_c = 1'b0;
      en_c    = 4'b0111;
      fl_c    = 4'b0100;
    end else if (!ihit) begin
      pc_en_c = 1'b0;
      fl_c    = 4'b1000;
    end
  end

  assign pc_en        = pc_en_c;
  assign if_id_en     = en_c[3];
  assign id_ex_en     = en_c[2];
  assign ex_mem_en    = en_c[1];
  assign mem_wb_en    = en_c[0];
  assign if_id_flush  = fl_c[3];
  assign id_ex_flush  = fl_c[2];
  assign ex_mem_flush = fl_c[1];
  assign mem_wb_flush = fl_c[0];
  assign halted       = halted_q;
  assign state_o      = state_q;

`ifdef HAZARD_PERF_EN
  logic stall_inc, flush_inc;

  assign stall_inc = !pc_en_c && (state_q != HZ_HALT);
  assign flush_inc = (fl_c[3] | fl_c[2]) && !RST;

  hazard_perf_ctr #(.W(PERFW)) u_stall_ctr (
    .clk (CLK),
    .rst (RST),
    .inc (stall_inc),
    .clr (RST),
    .cnt (stall_cycles)
  );

  hazard_perf_ctr #(.W(PERFW)) u_flush_ctr (
    .clk (CLK),
    .rst (RST),
    .inc (flush_inc),
    .clr (RST),
    .cnt (flush_events)
  );
`endif

endmodule
